// File: rtl/ysyx_23060203_trap_csr_if.sv
// Commit handshake bundle from EXU into the trap/CSR writeback stage.
// master = EXU side, slave = trap_csr side.
interface ysyx_23060203_trap_csr_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_dnpc;
  logic [4:0]  in_gpr_waddr;
  logic [31:0] in_gpr_wdata;
  logic        in_zicsr;
  logic [11:0] in_csr_waddr;
  logic [31:0] in_csr_wdata;
  logic        in_exc;
  logic [3:0]  in_cause;
  logic [31:0] in_tval;
  logic        in_ret;
  logic        in_fencei;

  modport master (
    output in_valid, in_pc, in_dnpc,
    output in_gpr_waddr, in_gpr_wdata,
    output in_zicsr, in_csr_waddr, in_csr_wdata,
    output in_exc, in_cause, in_tval,
    output in_ret, in_fencei,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_pc, in_dnpc,
    input  in_gpr_waddr, in_gpr_wdata,
    input  in_zicsr, in_csr_waddr, in_csr_wdata,
    input  in_exc, in_cause, in_tval,
    input  in_ret, in_fencei,
    output in_ready
  );
endinterface

// File: rtl/ysyx_23060203_trap_csr.sv
// Commit/writeback stage: M-mode CSRs, counters, trap sequencer, irq arbiter.
// Optional TRAP_VECTORED_EN: mtvec mode 1 vectors interrupts to base+4*cause.
module ysyx_23060203_trap_csr #(
  parameter int NUM_IRQ = 4,
  parameter int CNT_W   = 64,
  parameter int HART_ID = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  ysyx_23060203_trap_csr_if.slave cm,
  output logic                 gpr_wen,
  output logic [4:0]           gpr_waddr,
  output logic [31:0]          gpr_wdata,
  input  logic [11:0]          csr_raddr,
  output logic [31:0]          csr_rdata,
  input  logic [NUM_IRQ-1:0]   irq,
  input  logic                 clint_mtip,
  output logic                 irq_taken,
  output logic                 cs_flush,
  output logic [31:0]          cs_dnpc,
  output logic                 flush_icache,
  output logic [31:0]          csr_satp
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_SATP     = 12'h180;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;
  localparam logic [11:0] A_MINSTR   = 12'hB02;
  localparam logic [11:0] A_MINSTRH  = 12'hB82;
  localparam logic [11:0] A_MVENDOR  = 12'hF11;
  localparam logic [11:0] A_MARCH    = 12'hF12;
  localparam logic [11:0] A_MHART    = 12'hF14;

  localparam logic [31:0] IRQ_BITS =
    32'(((1 << NUM_IRQ) - 1) << 16);
  localparam logic [31:0] MIE_MASK = IRQ_BITS | 32'h80;
  localparam logic [63:0] CNT_MASK = (CNT_W == 64) ?
    64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;

  typedef enum logic {IDLE, REDIRECT} state_e;

  state_e state_q, state_d;

  logic [31:0] mstatus, mie_q, mtvec, mepc;
  logic [31:0] mcause, mtval, mscratch, satp;
  logic [63:0] mcycle, minstret, cyc_d, ret_d;
  logic [31:0] mip, pend, trap_base, int_tgt, tgt;
  logic [31:0] dnpc_q;
  logic        fi_q, irq_q, fi_d;
  logic [4:0]  int_cause;
  logic        accept, is_exc, is_ret, is_csr;
  logic        int_take, need_redir, csr_we;
  logic [11:0] wa;
  logic [31:0] wd;

  assign wa = cm.in_csr_waddr;
  assign wd = cm.in_csr_wdata;

  assign cm.in_ready = (state_q == IDLE);
  assign accept      = cm.in_valid & cm.in_ready;

  assign gpr_wen   = accept & ~cm.in_exc & (cm.in_gpr_waddr != 5'd0);
  assign gpr_waddr = cm.in_gpr_waddr;
  assign gpr_wdata = cm.in_gpr_wdata;

  always_comb begin
    mip     = '0;
    mip[7]  = clint_mtip;
    for (int i = 0; i < NUM_IRQ; i++) mip[16+i] = irq[i];
  end

  assign pend = mip & mie_q;

  // MTI wins; otherwise the lowest-numbered local line.
  always_comb begin
    int_cause = 5'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (pend[16+i]) int_cause = 5'(16 + i);
    if (pend[7]) int_cause = 5'd7;
  end

  assign is_exc = cm.in_exc;
  assign is_ret = ~cm.in_exc & cm.in_ret;
  assign is_csr = ~cm.in_exc & ~cm.in_ret & cm.in_zicsr;
  assign int_take = mstatus[3] & (|pend) & ~cm.in_exc
                  & ~cm.in_ret & ~cm.in_zicsr;
  assign need_redir = is_exc | is_ret | is_csr
                    | cm.in_fencei | int_take;
  assign csr_we = accept & is_csr;
  assign fi_d = ~cm.in_exc & (cm.in_fencei
              | (is_csr & (wa == A_SATP)));

  assign trap_base = {mtvec[31:2], 2'b00};
`ifdef TRAP_VECTORED_EN
  assign int_tgt = (mtvec[1:0] == 2'b01) ?
    trap_base + {25'd0, int_cause, 2'b00} : trap_base;
`else
  assign int_tgt = trap_base;
`endif

  always_comb begin
    tgt = cm.in_pc + 32'd4;
    if (is_exc)        tgt = trap_base;
    else if (is_ret)   tgt = mepc;
    else if (is_csr)   tgt = cm.in_pc + 32'd4;
    else if (int_take) tgt = int_tgt;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (accept & need_redir) state_d = REDIRECT;
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      dnpc_q  <= '0;
      fi_q    <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept & need_redir) begin
        dnpc_q <= tgt;
        fi_q   <= fi_d;
        irq_q  <= int_take;
      end
    end
  end

  assign cs_flush     = (state_q == REDIRECT);
  assign cs_dnpc      = dnpc_q;
  assign flush_icache = cs_flush & fi_q;
  assign irq_taken    = cs_flush & irq_q;
  assign csr_satp     = satp;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mstatus  <= 32'h0000_1800;
      mie_q    <= '0;
      mtvec    <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mtval    <= '0;
      mscratch <= '0;
      satp     <= '0;
    end else if (accept & (is_exc | int_take)) begin
      mepc          <= is_exc ? cm.in_pc : cm.in_dnpc;
      mcause        <= is_exc ? {28'd0, cm.in_cause}
                              : {1'b1, 26'd0, int_cause};
      mtval         <= is_exc ? cm.in_tval : '0;
      mstatus[7]    <= mstatus[3];
      mstatus[3]    <= 1'b0;
      mstatus[12:11] <= 2'b11;
    end else if (accept & is_ret) begin
      mstatus[3] <= mstatus[7];
      mstatus[7] <= 1'b1;
    end else if (csr_we) begin
      unique case (wa)
        A_MSTATUS:  mstatus  <= wd;
        A_MIE:      mie_q    <= wd & MIE_MASK;
`ifdef TRAP_VECTORED_EN
        A_MTVEC:    mtvec    <= wd;
`else
        A_MTVEC:    mtvec    <= {wd[31:2], 2'b00};
`endif
        A_MEPC:     mepc     <= {wd[31:2], 2'b00};
        A_MCAUSE:   mcause   <= wd;
        A_MTVAL:    mtval    <= wd;
        A_MSCRATCH: mscratch <= wd;
        A_SATP:     satp     <= wd;
        default: ;
      endcase
    end
  end

  // A write to either half replaces that cycle's increment.
  always_comb begin
    cyc_d = (mcycle + 64'd1) & CNT_MASK;
    ret_d = (accept & ~cm.in_exc) ?
      ((minstret + 64'd1) & CNT_MASK) : minstret;
    if (csr_we) begin
      unique case (wa)
        A_MCYCLE:  cyc_d = {mcycle[63:32], wd} & CNT_MASK;
        A_MCYCLEH: cyc_d = {wd, mcycle[31:0]} & CNT_MASK;
        A_MINSTR:  ret_d = {minstret[63:32], wd} & CNT_MASK;
        A_MINSTRH: ret_d = {wd, minstret[31:0]} & CNT_MASK;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      mcycle   <= cyc_d;
      minstret <= ret_d;
    end
  end

  always_comb begin
    csr_rdata = '0;
    unique case (csr_raddr)
      A_MSTATUS:  csr_rdata = mstatus;
      A_MIE:      csr_rdata = mie_q;
      A_MTVEC:    csr_rdata = mtvec;
      A_MSCRATCH: csr_rdata = mscratch;
      A_MEPC:     csr_rdata = mepc;
      A_MCAUSE:   csr_rdata = mcause;
      A_MTVAL:    csr_rdata = mtval;
      A_MIP:      csr_rdata = mip;
      A_SATP:     csr_rdata = satp;
      A_MCYCLE:   csr_rdata = mcycle[31:0];
      A_MCYCLEH:  csr_rdata = mcycle[63:32];
      A_MINSTR:   csr_rdata = minstret[31:0];
      A_MINSTRH:  csr_rdata = minstret[63:32];
      A_MVENDOR:  csr_rdata = 32'h7973_7978;
      A_MARCH:    csr_rdata = 32'h015f_deeb;
      A_MHART:    csr_rdata = 32'(HART_ID);
      default:    csr_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060203_trap_csr.sv
// Scoreboard bench for trap_csr: stimulus pushes expected redirects and
// GPR writes (tagged with the cycle they are due); a monitor pops/compares.
module tb_ysyx_23060203_trap_csr;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        gpr_wen;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic [11:0] csr_raddr = '0;
  logic [31:0] csr_rdata;
  logic [3:0]  irq = '0;
  logic        clint_mtip = 1'b0;
  logic        irq_taken, cs_flush, flush_icache;
  logic [31:0] cs_dnpc, csr_satp;

  always #5 clock = ~clock;

  ysyx_23060203_trap_csr_if bus();

  ysyx_23060203_trap_csr #(
    .NUM_IRQ(4), .CNT_W(64), .HART_ID(0)
  ) dut (
    .clock(clock), .reset(reset), .cm(bus),
    .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr),
    .gpr_wdata(gpr_wdata), .csr_raddr(csr_raddr),
    .csr_rdata(csr_rdata), .irq(irq),
    .clint_mtip(clint_mtip), .irq_taken(irq_taken),
    .cs_flush(cs_flush), .cs_dnpc(cs_dnpc),
    .flush_icache(flush_icache), .csr_satp(csr_satp)
  );

  int checks = 0;
  int fails  = 0;
  int ncyc   = 0;

  typedef struct {
    logic [31:0] dnpc; logic irq; logic fi; int due;
  } redir_t;
  typedef struct {
    logic [4:0] a; logic [31:0] d; int due;
  } gpr_t;
  typedef struct {
    logic [31:0] pc, dnpc; logic [4:0] wa; logic [31:0] wd;
    logic zicsr; logic [11:0] ca; logic [31:0] cd;
    logic exc; logic [3:0] cause; logic [31:0] tval;
    logic ret, fencei;
  } cm_t;

  redir_t rq[$];
  gpr_t   gq[$];

  logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc;
  logic [31:0] m_mcause, m_mtval, m_mscratch, m_satp;
  logic [63:0] m_minstret;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_mstatus = 32'h1800; m_mie = 0; m_mtvec = 0;
    m_mepc = 0; m_mcause = 0; m_mtval = 0;
    m_mscratch = 0; m_satp = 0; m_minstret = 0;
  endfunction

  function automatic logic [31:0] cur_mip();
    logic [31:0] m = 0;
    m[7] = clint_mtip;
    for (int i = 0; i < 4; i++) m[16+i] = irq[i];
    return m;
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return cur_mip();
      12'h180: return m_satp;
      12'hB02: return m_minstret[31:0];
      12'hB82: return m_minstret[63:32];
      12'hF11: return 32'h79737978;
      12'hF12: return 32'h015fdeeb;
      12'hF14: return 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  function automatic void enter_trap();
    m_mstatus[7] = m_mstatus[3];
    m_mstatus[3] = 1'b0;
    m_mstatus[12:11] = 2'b11;
  endfunction

  // Reference: spec-level commit semantics, evaluated at issue time.
  function automatic void model(input cm_t c);
    logic [31:0] pend = cur_mip() & m_mie;
    logic take = m_mstatus[3] && pend != 0
              && !c.exc && !c.ret && !c.zicsr;
    logic [63:0] old = m_minstret;
    redir_t r = '{dnpc: 0, irq: 0, fi: 0, due: ncyc + 2};
    logic need = 1'b1;
    int cause;
    if (!c.exc) m_minstret = old + 1;
    if (c.exc) begin
      m_mepc = c.pc; m_mcause = {28'h0, c.cause};
      m_mtval = c.tval; enter_trap();
      r.dnpc = m_mtvec & ~32'h3;
    end else if (c.ret) begin
      m_mstatus[3] = m_mstatus[7]; m_mstatus[7] = 1'b1;
      r.dnpc = m_mepc;
    end else if (c.zicsr) begin
      r.dnpc = c.pc + 4;
      case (c.ca)
        12'h300: m_mstatus = c.cd;
        12'h304: m_mie = c.cd & 32'h000F0080;
`ifdef TRAP_VECTORED_EN
        12'h305: m_mtvec = c.cd;
`else
        12'h305: m_mtvec = c.cd & ~32'h3;
`endif
        12'h340: m_mscratch = c.cd;
        12'h341: m_mepc = c.cd & ~32'h3;
        12'h342: m_mcause = c.cd;
        12'h343: m_mtval = c.cd;
        12'h180: m_satp = c.cd;
        12'hB02: m_minstret = {old[63:32], c.cd};
        12'hB82: m_minstret = {c.cd, old[31:0]};
        default: ;
      endcase
    end else if (take) begin
      cause = 0;
      if (pend[7]) cause = 7;
      else for (int i = 3; i >= 0; i--) if (pend[16+i]) cause = 16 + i;
      m_mepc = c.dnpc;
      m_mcause = 32'h80000000 | cause;
      m_mtval = 0; enter_trap();
      r.dnpc = m_mtvec & ~32'h3;
`ifdef TRAP_VECTORED_EN
      if (m_mtvec[1:0] == 2'b01) r.dnpc = r.dnpc + 4 * cause;
`endif
      r.irq = 1'b1;
    end else if (c.fencei) begin
      r.dnpc = c.pc + 4;
    end else begin
      need = 1'b0;
    end
    r.fi = !c.exc && (c.fencei
        || (!c.ret && c.zicsr && c.ca == 12'h180));
    if (need) rq.push_back(r);
    if (!c.exc && c.wa != 0)
      gq.push_back('{a: c.wa, d: c.wd, due: ncyc + 1});
  endfunction

  function automatic cm_t blank(input logic [31:0] pc);
    cm_t c = '{default: 0};
    c.pc = pc; c.dnpc = pc + 4;
    c.wa = 5'($urandom_range(1, 31)); c.wd = $urandom;
    return c;
  endfunction

  task automatic commit(input cm_t c);
    int w = 0;
    @(posedge clock); #1;
    while (!bus.in_ready && w < 8) begin
      @(posedge clock); #1; w++;
    end
    if (!bus.in_ready) begin
      checks++; fails++;
      $display("FAIL ready_timeout: in_ready stuck at 0, need 1");
    end
    bus.in_pc = c.pc; bus.in_dnpc = c.dnpc;
    bus.in_gpr_waddr = c.wa; bus.in_gpr_wdata = c.wd;
    bus.in_zicsr = c.zicsr; bus.in_csr_waddr = c.ca;
    bus.in_csr_wdata = c.cd; bus.in_exc = c.exc;
    bus.in_cause = c.cause; bus.in_tval = c.tval;
    bus.in_ret = c.ret; bus.in_fencei = c.fencei;
    bus.in_valid = 1'b1;
    model(c);
    @(posedge clock); #1;
    bus.in_valid = 1'b0; bus.in_zicsr = 0; bus.in_exc = 0;
    bus.in_ret = 0; bus.in_fencei = 0;
  endtask

  task automatic csrw(input logic [11:0] a, input logic [31:0] d,
                      input logic [31:0] pc);
    cm_t c = blank(pc);
    c.zicsr = 1; c.ca = a; c.cd = d;
    commit(c);
  endtask

  task automatic check_csr(input logic [11:0] a, input string name);
    csr_raddr = a;
    @(negedge clock);
    check(name, csr_rdata, model_read(a));
  endtask

  always @(negedge clock) begin
    redir_t r;
    gpr_t g;
    ncyc++;
    if (reset) begin
      if (rq.size() > 0 && rq[0].due == ncyc) begin
        r = rq.pop_front();
        check("cs_flush", 32'(cs_flush), 32'd1);
        check("cs_dnpc", cs_dnpc, r.dnpc);
        check("irq_taken", 32'(irq_taken), 32'(r.irq));
        check("flush_icache", 32'(flush_icache), 32'(r.fi));
        check("ready_in_redirect", 32'(bus.in_ready), 32'd0);
      end else begin
        check("idle_flush", 32'(cs_flush), 32'd0);
        check("idle_irq_taken", 32'(irq_taken), 32'd0);
      end
      if (gq.size() > 0 && gq[0].due == ncyc) begin
        g = gq.pop_front();
        check("gpr_wen", 32'(gpr_wen), 32'd1);
        check("gpr_waddr", 32'(gpr_waddr), 32'(g.a));
        check("gpr_wdata", gpr_wdata, g.d);
      end else begin
        check("gpr_idle", 32'(gpr_wen), 32'd0);
      end
    end
  end

  localparam logic [11:0] WADDRS [12] = '{
    12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
    12'h343, 12'h180, 12'hB02, 12'hB82, 12'h7C0, 12'h344};
  localparam logic [11:0] RADDRS [16] = '{
    12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
    12'h343, 12'h344, 12'h180, 12'hB02, 12'hB82, 12'hF11,
    12'hF12, 12'hF14, 12'h7C0, 12'h123};

  initial begin
    cm_t c;
    logic [31:0] v;
    bus.in_valid = 0; bus.in_pc = 0; bus.in_dnpc = 0;
    bus.in_gpr_waddr = 0; bus.in_gpr_wdata = 0;
    bus.in_zicsr = 0; bus.in_csr_waddr = 0; bus.in_csr_wdata = 0;
    bus.in_exc = 0; bus.in_cause = 0; bus.in_tval = 0;
    bus.in_ret = 0; bus.in_fencei = 0;
    model_reset();
    repeat (3) @(posedge clock);
    @(negedge clock) reset = 1'b1;
    repeat (10) @(posedge clock);
    csr_raddr = 12'hB00;
    @(negedge clock);
    checks++;
    if (csr_rdata < 9 || csr_rdata > 11) begin
      fails++;
      $display("FAIL mcycle_idle: got %0d expected 10+-1", csr_rdata);
    end
    check("reset_flush", 32'(cs_flush), 32'd0);
    check_csr(12'h300, "reset_mstatus");
    check_csr(12'hF11, "mvendorid");
    check_csr(12'hF12, "marchid");

    // Synchronous exception.
    csrw(12'h305, 32'h80001000, 32'h80000000);
    c = blank(32'h80000100);
    c.exc = 1; c.cause = 4'd11; c.tval = 0;
    commit(c);
    check("ready_low", 32'(bus.in_ready), 32'd0);
    @(posedge clock); #1;
    check("ready_back", 32'(bus.in_ready), 32'd1);
    check_csr(12'h341, "exc_mepc");
    check_csr(12'h342, "exc_mcause");
    check_csr(12'h300, "exc_mstatus");

    // Counter write overrides increment; read returns written value.
    csrw(12'hB00, 32'h00001000, 32'h80000010);
    csr_raddr = 12'hB00;
    @(negedge clock);
    check("mcycle_write", csr_rdata, 32'h00001000);

    // irq[1], deferred across a zicsr commit.
    csrw(12'h300, 32'h00001888, 32'h80000020);
    csrw(12'h304, 32'h00020000, 32'h80000024);
    irq = 4'b0010;
    csrw(12'h340, 32'h00000055, 32'h80000028);
    c = blank(32'h80000200);
    c.dnpc = 32'h80000204;
    commit(c);
    check_csr(12'h342, "irq1_mcause");
    check_csr(12'h341, "irq1_mepc");
    check_csr(12'h344, "mip_read");

    // MTI beats irq[0].
    irq = 4'b0000;
    csrw(12'h304, 32'h00010080, 32'h80000030);
    csrw(12'h300, 32'h00001888, 32'h80000034);
    clint_mtip = 1; irq = 4'b0001;
    commit(blank(32'h80000300));
    check_csr(12'h342, "mti_mcause");

    // mret restores MIE from MPIE.
    clint_mtip = 0; irq = 0;
    c = blank(32'h80001000);
    c.ret = 1;
    commit(c);
    check_csr(12'h300, "mret_mstatus");

    // Vectored mode (base only when the feature is compiled out).
    csrw(12'h304, 32'h00040000, 32'h80000040);
    csrw(12'h305, 32'h80001001, 32'h80000044);
    check_csr(12'h305, "mtvec_mode");
    irq = 4'b0100;
    commit(blank(32'h80000400));
    irq = 0;

    // Unknown CSR, fence.i, satp and x0 writes.
    csrw(12'h7C0, 32'hDEADBEEF, 32'h80000050);
    check_csr(12'h7C0, "unknown_csr");
    c = blank(32'h80000060); c.fencei = 1; commit(c);
    csrw(12'h180, 32'h80012345, 32'h80000064);
    check("csr_satp", csr_satp, m_satp);
    c = blank(32'h80000068); c.wa = 0; commit(c);

    for (int n = 0; n < 300; n++) begin
      int k = $urandom_range(0, 99);
      if ($urandom_range(0, 3) == 0) irq = 4'($urandom);
      if ($urandom_range(0, 5) == 0) clint_mtip = 1'($urandom);
      c = blank($urandom & ~32'h3);
      c.dnpc = $urandom & ~32'h3;
      if (k < 12) begin
        c.exc = 1; c.cause = 4'($urandom); c.tval = $urandom;
      end else if (k < 22) c.ret = 1;
      else if (k < 55) begin
        c.zicsr = 1;
        c.ca = WADDRS[$urandom_range(0, 11)];
        c.cd = $urandom;
      end else if (k < 62) c.fencei = 1;
      if ($urandom_range(0, 9) == 0) c.fencei = 1;
      if ($urandom_range(0, 15) == 0) c.ret = 1;
      if ($urandom_range(0, 7) == 0) c.wa = 0;
      commit(c);
      if ($urandom_range(0, 2) == 0)
        check_csr(RADDRS[$urandom_range(0, 15)], "rand_csr");
    end
    irq = 0; clint_mtip = 0;
    check_csr(12'hB02, "minstret_lo");
    check_csr(12'hB82, "minstret_hi");
    check_csr(12'h300, "final_mstatus");

    // Async reset during the redirect cycle.
    c = blank(32'h80000500); c.exc = 1; c.cause = 4'd2;
    commit(c);
    v = 32'(cs_flush);
    check("flush_before_reset", v, 32'd1);
    reset = 1'b0;
    #1;
    check("flush_on_reset", 32'(cs_flush), 32'd0);
    rq.delete(); gq.delete();
    model_reset();
    @(posedge clock); #2;
    reset = 1'b1;
    check_csr(12'h300, "rereset_mstatus");
    check_csr(12'hB02, "rereset_minstret");

    repeat (4) @(posedge clock);
    @(negedge clock);
    check("queue_drain", 32'(rq.size() + gq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/ysyx_23060203_trap_csr.md
Name: ysyx_23060203_trap_csr

Overview:
Parametrised commit/writeback stage with machine-mode CSR file, trap sequencer and multi-source interrupt arbitration. Sits after EXU. Drives the GPR write port, holds M-mode CSRs and 64-bit counters, and issues a registered control-flow redirect (cs_flush/cs_dnpc) to the CSU on traps, mret, fence.i and CSR writes. Unlike the previous stage, it supports N local interrupt lines, mie/mip, mtval, cause codes from EXU, counters and a one-cycle redirect FSM with back-pressure.

Parameters:
NUM_IRQ, 4, local interrupt lines irq[i], reported as mcause 16+i
CNT_W, 64, width of mcycle/minstret (32 or 64; high CSR halves read 0 when 32)
HART_ID, 0, value returned by mhartid (0xF14)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
in_valid  in  1  commit valid from EXU
in_ready  out  1  commit accept; 0 while in REDIRECT
in_pc  in  32  PC of committing instruction
in_dnpc  in  32  next PC of committing instruction
in_gpr_waddr  in  5  destination register
in_gpr_wdata  in  32  destination data
in_zicsr  in  1  CSR-write instruction
in_csr_waddr  in  12  CSR address
in_csr_wdata  in  32  CSR write data
in_exc  in  1  synchronous exception
in_cause  in  4  exception cause code
in_tval  in  32  exception value
in_ret  in  1  mret
in_fencei  in  1  fence.i
gpr_wen  out  1  GPR write enable
gpr_waddr  out  5  GPR write address
gpr_wdata  out  32  GPR write data
csr_raddr  in  12  CSR read address
csr_rdata  out  32  CSR read data (combinational)
irq  in  NUM_IRQ  level-sensitive local interrupts
clint_mtip  in  1  timer interrupt pending
irq_taken  out  1  pulse in the REDIRECT cycle of an interrupt trap
cs_flush  out  1  redirect pulse
cs_dnpc  out  32  redirect target
flush_icache  out  1  pulse with cs_flush for fence.i or satp write
csr_satp  out  32  satp value

Behaviour:
- Accept = in_valid & in_ready. gpr_wen = accept & ~in_exc & (in_gpr_waddr != 0). gpr_waddr/gpr_wdata pass through.
- FSM: IDLE, REDIRECT. IDLE->REDIRECT on accept of exc | ret | zicsr | fencei | interrupt-take. REDIRECT->IDLE unconditionally after one cycle. in_ready = (state == IDLE). cs_flush = (state == REDIRECT). Redirect target and flags are registered at accept.
- Priority at one accepted commit: exc > ret > zicsr > interrupt > plain. Interrupt taken only when mstatus.MIE = 1, any (mip & mie) != 0 and the commit is plain or fencei. Zicsr/exc/ret commits defer the interrupt to the next commit.
- Interrupt arbitration: MTI (cause 7) highest, then irq[0] (cause 16) through irq[NUM_IRQ-1]. mip[7] = clint_mtip, mip[16+i] = irq[i]; mip is read-only.
- Exception: mepc <= in_pc, mcause <= {28'b0, in_cause}, mtval <= in_tval, MPIE <= MIE, MIE <= 0, MPP <= 2'b11; target = trap base.
- Interrupt: mepc <= in_dnpc, mcause <= {1'b1, 31'(cause)}, mtval <= 0, MPIE/MIE/MPP as for exception; irq_taken pulses.
- mret: MIE <= MPIE, MPIE <= 1; target = mepc.
- zicsr/fencei: target = in_pc + 4.
- CSR writes: mstatus, mie (only bits 7 and 16..16+NUM_IRQ-1 writable), mtvec, mepc (bits [1:0] forced 0), mcause, mtval, mscratch, satp, mcycle/h, minstret/h. Unknown addresses are ignored and read 0. mvendorid = 0x79737978, marchid = 0x015fdeeb.
- Counters: mcycle +1 every cycle. minstret +1 per accepted non-exc commit. Both wrap at 2^CNT_W. A CSR write to a counter half overrides that cycle's increment. Reads return pre-write values.
- flush_icache pulses with cs_flush when the registered commit was fencei or a satp write.
- Reset (async, any state): state IDLE, cs_flush 0, irq_taken 0, flush_icache 0, mstatus 0x1800, all other CSRs and counters 0.

Optional Feature:
TRAP_VECTORED_EN. When defined, mtvec[1:0] is writable: mode 1 gives interrupt target = {mtvec[31:2],2'b00} + 4*cause, and exceptions still use the base. When not defined, mtvec[1:0] reads 0 and all traps use the base.

Test Plan:
- Reset release, idle 10 cycles -> mcycle reads 10 (±1 for sampling), cs_flush 0, mstatus 0x1800.
- mtvec=0x80001000; exc commit pc=0x80000100, cause=11, tval=0 -> next cycle cs_flush=1, cs_dnpc=0x80001000, mepc=0x80000100, mcause=11, MIE=0, in_ready=0 for that cycle only.
- MIE=1, mie[17]=1, irq[1]=1; plain commit with dnpc=0x80000204 -> mcause=0x80000011, mepc=0x80000204, irq_taken pulse; same commit as zicsr -> no trap, trap on following commit.
- clint_mtip=1 and irq[0]=1, both enabled -> mcause=0x80000007.
- mret with MPIE=1 -> cs_dnpc=mepc, MIE=1; reset asserted in REDIRECT -> cs_flush drops immediately.
- TRAP_VECTORED_EN, mtvec=0x80001001, irq[2] taken -> cs_dnpc=0x80001048. Without the macro, mtvec reads 0x80001000 and cs_dnpc=0x80001000.
